// File: rtl/haz_pkg.sv
// Shared constants and types for the hazard/forwarding unit: forward-select
// codes, the destination record carried down the shadow pipeline, and timer states.
package haz_pkg;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX      = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  // Records hold register numbers zero-extended to this width (RA_W must not exceed it).
  localparam int DST_MAX_W = 8;

  typedef struct packed {
    logic                 v;
    logic                 ld;
    logic [DST_MAX_W-1:0] dst;
  } dst_rec_t;

  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

endpackage

// File: rtl/haz_md_timer.sv
// MUL/DIV busy timer: IDLE/BUSY FSM with a down-counter; done pulses on the
// final busy cycle. kill aborts a running count without a done pulse.
module haz_md_timer
  import haz_pkg::*;
#(
  parameter int MD_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic kill,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(MD_CYCLES);

  logic [0:0]    state;
  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      count <= '0;
    end else if (kill) begin
      state <= MD_IDLE;
      count <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state <= MD_BUSY;
            count <= CW'(MD_CYCLES - 1);
          end
        end
        MD_BUSY: begin
          if (count == '0) state <= MD_IDLE;
          else             count <= count - CW'(1);
        end
        default: begin
          state <= MD_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign busy = (state == MD_BUSY);
  assign done = (state == MD_BUSY) && (count == '0);

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the 5-stage pipeline, with a
// MUL/DIV busy interlock. Define HAZ_PERF_EN to add stall/flush cycle counters.
module hazard_fwd_unit
  import haz_pkg::*;
#(
  parameter int RA_W      = 5,
  parameter int NUM_SRC   = 2,
  parameter int MD_CYCLES = 8,
  parameter int PERF_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*RA_W-1:0]   id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_wreg,
  input  logic [RA_W-1:0]           id_dst,
  input  logic                      id_is_load,
  input  logic                      id_md_start,
  input  logic                      id_md_read,
  input  logic                      flush,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      bubble,
  output logic                      md_busy,
  output logic                      md_done
`ifdef HAZ_PERF_EN
  ,
  output logic [PERF_W-1:0]         perf_stall_cnt,
  output logic [PERF_W-1:0]         perf_flush_cnt
`endif
);

  dst_rec_t rec_p0;  // EX
  dst_rec_t rec_p1;  // MEM
  dst_rec_t rec_p2;  // WB
  dst_rec_t id_rec;
  logic     load_use;
  logic     md_hazard;
  logic     md_start;

  always_comb begin
    id_rec = '0;
    if (id_valid && id_wreg && (id_dst != '0)) begin
      id_rec.v   = 1'b1;
      id_rec.ld  = id_is_load;
      id_rec.dst = DST_MAX_W'(id_dst);
    end
  end

  // Per-operand select; a load sitting in EX cannot forward yet, so it
  // falls through to the MEM check and raises load_use instead.
  always_comb begin
    logic [DST_MAX_W-1:0] src;
    src      = '0;
    fwd_sel  = '0;
    load_use = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src = DST_MAX_W'(id_src[k*RA_W +: RA_W]);
      if (id_src_used[k] && (src != '0)) begin
        if (rec_p0.v && !rec_p0.ld && (rec_p0.dst == src))
          fwd_sel[k*2 +: 2] = FWD_EX;
        else if (rec_p1.v && (rec_p1.dst == src))
          fwd_sel[k*2 +: 2] = rec_p1.ld ? FWD_MEM_LD : FWD_MEM_ALU;
        if (rec_p0.v && rec_p0.ld && (rec_p0.dst == src))
          load_use = 1'b1;
      end
    end
  end

  assign md_hazard = md_busy && (id_md_start || id_md_read);
  assign stall     = !flush && id_valid && (load_use || md_hazard);
  assign bubble    = flush || stall;
  assign md_start  = id_valid && id_md_start && !stall && !flush;

  // ID -> EX -> MEM -> WB record shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_p0 <= '0;
      rec_p1 <= '0;
      rec_p2 <= '0;
    end else begin
      rec_p0 <= bubble ? '0 : id_rec;
      rec_p1 <= rec_p0;
      rec_p2 <= rec_p1;
    end
  end

  // kill is held low here; it exists for an exception-abort path.
  haz_md_timer #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .kill  (1'b0),
    .busy  (md_busy),
    .done  (md_done)
  );

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      if (flush && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed pipeline scenarios plus a
// randomized run against a queue-based reference model.
module tb_hazard_fwd_unit;

  localparam int RA_W = 5;
  localparam int NSRC = 2;
  localparam int MD   = 8;
  localparam int PW   = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic [NSRC*RA_W-1:0] id_src;
  logic [NSRC-1:0] id_src_used;
  logic            id_wreg;
  logic [RA_W-1:0] id_dst;
  logic            id_is_load;
  logic            id_md_start;
  logic            id_md_read;
  logic            flush;
  logic [NSRC*2-1:0] fwd_sel;
  logic            stall, bubble, md_busy, md_done;
`ifdef HAZ_PERF_EN
  logic [PW-1:0]   perf_stall_cnt, perf_flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(
    .RA_W(RA_W), .NUM_SRC(NSRC), .MD_CYCLES(MD), .PERF_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_wreg(id_wreg), .id_dst(id_dst),
    .id_is_load(id_is_load), .id_md_start(id_md_start), .id_md_read(id_md_read),
    .flush(flush), .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble),
    .md_busy(md_busy), .md_done(md_done)
`ifdef HAZ_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input int s0, input int s1, input logic [1:0] used,
                        input logic wr, input int dst, input logic ld,
                        input logic mds, input logic mdr, input logic fl);
    id_valid    = v;
    id_src      = {RA_W'(s1), RA_W'(s0)};
    id_src_used = used;
    id_wreg     = wr;
    id_dst      = RA_W'(dst);
    id_is_load  = ld;
    id_md_start = mds;
    id_md_read  = mdr;
    flush       = fl;
  endtask

  task automatic idle_in;
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain;
    idle_in();
    repeat (4) tick();
  endtask

  task automatic test_reset;
    idle_in();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_tests++; if (fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd_sel got %b want 0000", fwd_sel); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_tests++; if (bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got %b want 0", bubble); end
    n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy got %b want 0", md_busy); end
    n_tests++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL reset_md_done got %b want 0", md_done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fwd_ex;
    drain();
    set_in(1, 1, 2, 2'b11, 1, 3, 0, 0, 0, 0);       // add $3,$1,$2
    tick();
    set_in(1, 3, 5, 2'b11, 1, 4, 0, 0, 0, 0);       // sub $4,$3,$5
    #1;
    n_tests++; if (fwd_sel !== 4'b0001) begin n_fail++; $display("FAIL fwd_ex_sel got %b want 0001", fwd_sel); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fwd_ex_stall got %b want 0", stall); end
    tick();
    set_in(1, 5, 3, 2'b11, 1, 6, 0, 0, 0, 0);       // or $6,$5,$3 : $3 now in MEM
    #1;
    n_tests++; if (fwd_sel !== 4'b1000) begin n_fail++; $display("FAIL fwd_mem_alu_sel got %b want 1000", fwd_sel); end
  endtask

  task automatic test_load_use;
    drain();
    set_in(1, 1, 0, 2'b01, 1, 3, 1, 0, 0, 0);       // lw $3,0($1)
    tick();
    set_in(1, 3, 3, 2'b11, 1, 4, 0, 0, 0, 0);       // add $4,$3,$3
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall got %b want 1", stall); end
    n_tests++; if (bubble !== 1'b1) begin n_fail++; $display("FAIL load_use_bubble got %b want 1", bubble); end
    tick();
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release got %b want 0", stall); end
    n_tests++; if (fwd_sel !== 4'b1111) begin n_fail++; $display("FAIL load_use_fwd got %b want 1111", fwd_sel); end
  endtask

  task automatic test_r0;
    drain();
    set_in(1, 1, 2, 2'b11, 1, 0, 0, 0, 0, 0);       // add $0,$1,$2
    tick();
    set_in(1, 0, 0, 2'b11, 1, 5, 0, 0, 0, 0);       // or $5,$0,$0
    #1;
    n_tests++; if (fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL r0_fwd got %b want 0000", fwd_sel); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall got %b want 0", stall); end
    drain();
    set_in(1, 1, 0, 2'b01, 1, 0, 1, 0, 0, 0);       // lw $0
    tick();
    set_in(1, 0, 0, 2'b11, 1, 7, 0, 0, 0, 0);
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_load_stall got %b want 0", stall); end
  endtask

  task automatic test_md;
    drain();
    set_in(1, 1, 2, 2'b11, 0, 0, 0, 1, 0, 0);       // mult at t0
    #1;
    n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md_t0_busy got %b want 0", md_busy); end
    tick();
    set_in(1, 0, 0, 2'b00, 1, 8, 0, 0, 1, 0);       // mfhi $8
    for (int i = 1; i <= MD; i++) begin
      #1;
      n_tests++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL md_busy t0+%0d got %b want 1", i, md_busy); end
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL md_stall t0+%0d got %b want 1", i, stall); end
      n_tests++; if (md_done !== (i == MD)) begin n_fail++; $display("FAIL md_done t0+%0d got %b want %b", i, md_done, (i == MD)); end
      tick();
    end
    #1;
    n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md_end_busy got %b want 0", md_busy); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL md_end_stall got %b want 0", stall); end
  endtask

  task automatic test_flush;
    drain();
    set_in(1, 1, 0, 2'b01, 1, 3, 1, 0, 0, 0);       // lw $3 -> EX
    tick();
    set_in(1, 3, 3, 2'b11, 1, 4, 0, 1, 0, 1);       // dependent + md_start under flush
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", stall); end
    n_tests++; if (bubble !== 1'b1) begin n_fail++; $display("FAIL flush_bubble got %b want 1", bubble); end
    tick();
    set_in(1, 4, 3, 2'b11, 1, 9, 0, 0, 0, 0);
    #1;
    n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL flush_md_busy got %b want 0", md_busy); end
    n_tests++; if (fwd_sel !== 4'b1100) begin n_fail++; $display("FAIL flush_ex_invalid got %b want 1100", fwd_sel); end
  endtask

  task automatic test_reset_busy;
    drain();
    set_in(1, 1, 2, 2'b11, 0, 0, 0, 1, 0, 0);
    tick();
    idle_in();
    repeat (3) tick();                             // count now 4
    #1;
    n_tests++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL rstb_pre_busy got %b want 1", md_busy); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rstb_busy got %b want 0", md_busy); end
    n_tests++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL rstb_done got %b want 0", md_done); end
`ifdef HAZ_PERF_EN
    n_tests++; if (perf_stall_cnt !== '0) begin n_fail++; $display("FAIL rstb_perf_stall got %0d want 0", perf_stall_cnt); end
    n_tests++; if (perf_flush_cnt !== '0) begin n_fail++; $display("FAIL rstb_perf_flush got %0d want 0", perf_flush_cnt); end
`endif
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < MD; i++) begin
      tick();
      #1;
      n_tests++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL rstb_no_done cyc %0d got %b want 0", i, md_done); end
    end
  endtask

  typedef struct { bit v; bit ld; int dst; } mrec_t;

  task automatic test_random;
    mrec_t hist[$];
    int    md_left, s, e_fwd, n_stall, n_flush;
    bit    lu, e_stall, e_bubble;
    logic [3:0] e_sel;
    hist = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    md_left = 0; n_stall = 0; n_flush = 0;
    idle_in();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(9) != 0, $urandom_range(4), $urandom_range(4), 2'($urandom),
             $urandom_range(3) != 0, $urandom_range(4), $urandom_range(9) < 3,
             $urandom_range(11) == 0, $urandom_range(11) == 0, $urandom_range(9) == 0);
      #1;
      e_sel = '0; lu = 0;
      for (int k = 0; k < NSRC; k++) begin
        s = int'(id_src[k*RA_W +: RA_W]);
        e_fwd = 0;
        if (id_src_used[k] && s != 0) begin
          if (hist[0].v && !hist[0].ld && hist[0].dst == s) e_fwd = 1;
          else if (hist[1].v && hist[1].dst == s) e_fwd = hist[1].ld ? 3 : 2;
          if (hist[0].v && hist[0].ld && hist[0].dst == s) lu = 1;
        end
        e_sel[k*2 +: 2] = 2'(e_fwd);
      end
      e_stall  = !flush && id_valid && (lu || (md_left > 0 && (id_md_start || id_md_read)));
      e_bubble = flush || e_stall;
      n_tests++; if (fwd_sel !== e_sel) begin n_fail++; $display("FAIL rnd_fwd cyc %0d got %b want %b", c, fwd_sel, e_sel); end
      n_tests++; if (stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall cyc %0d got %b want %b", c, stall, e_stall); end
      n_tests++; if (bubble !== e_bubble) begin n_fail++; $display("FAIL rnd_bubble cyc %0d got %b want %b", c, bubble, e_bubble); end
      n_tests++; if (md_busy !== (md_left > 0)) begin n_fail++; $display("FAIL rnd_md_busy cyc %0d got %b want %b", c, md_busy, (md_left > 0)); end
      n_tests++; if (md_done !== (md_left == 1)) begin n_fail++; $display("FAIL rnd_md_done cyc %0d got %b want %b", c, md_done, (md_left == 1)); end
      if (e_bubble) hist.push_front('{0, 0, 0});
      else hist.push_front('{id_valid && id_wreg && id_dst != 0, id_is_load, int'(id_dst)});
      void'(hist.pop_back());
      if (md_left > 0) md_left--;
      else if (id_valid && id_md_start && !e_stall && !flush) md_left = MD;
      if (e_stall) n_stall++;
      if (flush) n_flush++;
      tick();
    end
`ifdef HAZ_PERF_EN
    #1;
    n_tests++; if (perf_stall_cnt !== PW'(n_stall)) begin n_fail++; $display("FAIL rnd_perf_stall got %0d want %0d", perf_stall_cnt, n_stall); end
    n_tests++; if (perf_flush_cnt !== PW'(n_flush)) begin n_fail++; $display("FAIL rnd_perf_flush got %0d want %0d", perf_flush_cnt, n_flush); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_r0();
    test_md();
    test_flush();
    test_reset_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised hazard-detection and forwarding unit for the 5-stage MIPS pipeline; successor to the fixed 2-operand control-unit hazard logic. Keeps its own shadow pipeline of destination records (EX, MEM, WB) and generates per-operand forward selects, load-use stalls, and branch-flush bubbles. Adds a busy-timer FSM for a multi-cycle MUL/DIV unit. Sits beside the ID stage; outputs drive the ID/EX operand muxes and the PC/IF-ID write enables.

Parameters:
RA_W, 5, register address width
NUM_SRC, 2, number of source operands checked (2 or 3)
MD_CYCLES, 8, MUL/DIV busy cycles after issue (>=2)
PERF_W, 32, width of optional performance counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_src  in  NUM_SRC*RA_W  source register numbers, operand k at [k*RA_W +: RA_W]
id_src_used  in  NUM_SRC  operand k actually read
id_wreg  in  1  ID instruction writes a GPR
id_dst  in  RA_W  resolved destination register (rd/rt/31)
id_is_load  in  1  ID instruction is LW
id_md_start  in  1  ID instruction issues MUL/DIV
id_md_read  in  1  ID instruction reads HI/LO
flush  in  1  taken branch/jump resolved in ID; squash IF/ID
fwd_sel  out  NUM_SRC*2  per-operand select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
stall  out  1  hold PC and IF/ID (active-high; active-low write enable = ~stall)
bubble  out  1  load NOP into ID/EX this cycle
md_busy  out  1  MUL/DIV timer running
md_done  out  1  one-cycle pulse on the last busy cycle

Behaviour:
- Reset (rst_n=0, async): EX/MEM/WB records invalid (all fields 0), timer IDLE, count 0; fwd_sel=0, stall=0, bubble=0, md_busy=0, md_done=0.
- Record = {v, ld, dst}; v=id_valid&id_wreg&(id_dst!=0). Each posedge: WB<=MEM, MEM<=EX, EX<=ID record if ~bubble, else zero record.
- fwd_sel, stall, bubble are combinational from the ID inputs and the registered records (same cycle, zero latency).
- Per operand k (used, src!=0): EX match & ~EX.ld -> 01; else MEM match -> (MEM.ld ? 11 : 10); else 00. EX has priority over MEM. WB is covered by regfile write-first; no WB path.
- Load-use: any used src matches EX.dst with EX.v&EX.ld -> stall=1, bubble=1 for exactly one cycle; next cycle the load is in MEM and selects 11.
- MD hazard: timer BUSY and ID has id_md_start or id_md_read -> stall=1, bubble=1 until the cycle after md_done.
- Timer FSM: IDLE --(id_md_start & id_valid & ~stall & ~flush)--> BUSY with count=MD_CYCLES-1; BUSY decrements each cycle; md_done=1 when count==0, then -> IDLE. md_busy=1 in BUSY.
- flush: bubble=1, stall=0 (flush overrides every stall source); ID record is not entered; MD start is suppressed.
- Register 0 never matches: no forward, no stall.
- rst_n mid-BUSY: timer returns to IDLE immediately, no md_done pulse.

Optional Feature:
HAZ_PERF_EN: when defined, adds outputs perf_stall_cnt, perf_flush_cnt (PERF_W each). They count cycles with stall=1 and cycles with flush=1, saturate at all-ones, and reset to 0. When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package haz_pkg holds FWD_RF/FWD_EX/FWD_MEM_ALU/FWD_MEM_LD (2-bit constants), the dst-record typedef, and the timer state encoding.
- One sub-module, haz_md_timer, contains the IDLE/BUSY FSM and down-counter (inputs start and kill; outputs busy and done).

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 -> fwd_sel[1:0]=01 for operand 0, stall=0.
- lw $3,0($1) then add $4,$3,$3 -> stall=1, bubble=1 for one cycle; next cycle both operands select 11.
- add $0,$1,$2 then or $5,$0,$0 -> fwd_sel=0, stall=0.
- mult at t0 (MD_CYCLES=8) then mfhi -> md_busy for 8 cycles, md_done at t0+8, stall held until md_done, mfhi enters EX at t0+9.
- lw $3 in EX with flush=1 and a dependent instruction in ID -> stall=0, bubble=1, no MD start; next EX record is invalid.
- rst_n low during BUSY count 4 -> md_busy=0 immediately, no md_done; with HAZ_PERF_EN, counters read 0.
